// File: rtl/mem_load_pkg.sv
// Shared widths, memory depth and controller state encoding for the memory loader.
package mem_load_pkg;

  localparam int unsigned ADDRESS_WIDTH = 11;
  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned MEM_DEPTH     = 2048;
  localparam int unsigned COUNT_WIDTH   = 12;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IM,
    LOAD_DM,
    DRAIN,
    RELEASE,
    RUN
  } state_t;

  // Clamp a requested word count to the memory depth.
  function automatic logic [COUNT_WIDTH-1:0] sat_count(input logic [COUNT_WIDTH-1:0] words);
    if (words > COUNT_WIDTH'(MEM_DEPTH)) begin
      return COUNT_WIDTH'(MEM_DEPTH);
    end
    return words;
  endfunction

endpackage

// File: rtl/load_port_driver.sv
// Drives one RAM port during loading: address counter plus a registered one-cycle write strobe.
module load_port_driver #(
  parameter int unsigned ADDRESS_WIDTH = 11,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic [ADDRESS_WIDTH-1:0] idx,
  output logic                     cen_load,
  output logic                     wen_load,
  output logic                     oen_load,
  output logic [ADDRESS_WIDTH-1:0] addr_load,
  output logic [DATA_WIDTH-1:0]    datain_load
);

  // Strobes idle high; an accepted word becomes a write at the current index next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      cen_load    <= 1'b1;
      wen_load    <= 1'b1;
      oen_load    <= 1'b1;
      addr_load   <= '0;
      datain_load <= '0;
    end else begin
      cen_load <= 1'b1;
      wen_load <= 1'b1;
      oen_load <= 1'b1;
      if (clear) begin
        idx <= '0;
      end else if (wr_en) begin
        cen_load    <= 1'b0;
        wen_load    <= 1'b0;
        addr_load   <= idx;
        datain_load <= wr_data;
        idx         <= idx + ADDRESS_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/mem_load_controller.sv
// Streams IM then DM words into the processor memories, then releases the processor reset.
module mem_load_controller #(
  parameter int unsigned ADDRESS_WIDTH = mem_load_pkg::ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = mem_load_pkg::DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [11:0]              im_words,
  input  logic [11:0]              dm_words,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic                     loading,
  output logic                     im_cen_load,
  output logic                     im_wen_load,
  output logic                     im_oen_load,
  output logic [ADDRESS_WIDTH-1:0] im_addr_load,
  output logic [DATA_WIDTH-1:0]    im_datain_load,
  output logic                     dm_cen_load,
  output logic                     dm_wen_load,
  output logic                     dm_oen_load,
  output logic [ADDRESS_WIDTH-1:0] dm_addr_load,
  output logic [DATA_WIDTH-1:0]    dm_datain_load,
  output logic                     cpu_rst_n,
  output logic                     busy,
  output logic                     done
);

  import mem_load_pkg::*;

  state_t                   state;
  logic [COUNT_WIDTH-1:0]   im_cnt;
  logic [COUNT_WIDTH-1:0]   dm_cnt;
  logic                     rel_cnt;
  logic [ADDRESS_WIDTH-1:0] im_idx;
  logic [ADDRESS_WIDTH-1:0] dm_idx;
  logic                     start_acc;
  logic                     im_acc;
  logic                     dm_acc;
  logic                     im_last;
  logic                     dm_last;

  // Handshake and last-word decode; the index already counts every earlier accept.
  assign start_acc = start && ((state == IDLE) || (state == RUN));
  assign in_ready  = (state == LOAD_IM) || (state == LOAD_DM);
  assign busy      = (state != IDLE) && (state != RUN);
  assign im_acc    = in_valid && (state == LOAD_IM);
  assign dm_acc    = in_valid && (state == LOAD_DM);
  assign im_last   = (COUNT_WIDTH'(im_idx) == (im_cnt - COUNT_WIDTH'(1)));
  assign dm_last   = (COUNT_WIDTH'(dm_idx) == (dm_cnt - COUNT_WIDTH'(1)));

  // Session sequencing with registered loading/cpu_rst_n/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      im_cnt    <= '0;
      dm_cnt    <= '0;
      rel_cnt   <= 1'b0;
      loading   <= 1'b1;
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (start) begin
            im_cnt    <= sat_count(im_words);
            dm_cnt    <= sat_count(dm_words);
            loading   <= 1'b1;
            cpu_rst_n <= 1'b0;
            if (im_words != '0) begin
              state <= LOAD_IM;
            end else if (dm_words != '0) begin
              state <= LOAD_DM;
            end else begin
              state <= DRAIN;
            end
          end
        end
        LOAD_IM: begin
          if (im_acc && im_last) begin
            state <= (dm_cnt != '0) ? LOAD_DM : DRAIN;
          end
        end
        LOAD_DM: begin
          if (dm_acc && dm_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          state   <= RELEASE;
          loading <= 1'b0;
          rel_cnt <= 1'b0;
        end
        RELEASE: begin
          if (rel_cnt) begin
            state     <= RUN;
            cpu_rst_n <= 1'b1;
            done      <= 1'b1;
          end else begin
            rel_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  load_port_driver #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_im_port (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_acc),
    .wr_en      (im_acc),
    .wr_data    (in_data),
    .idx        (im_idx),
    .cen_load   (im_cen_load),
    .wen_load   (im_wen_load),
    .oen_load   (im_oen_load),
    .addr_load  (im_addr_load),
    .datain_load(im_datain_load)
  );

  load_port_driver #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_dm_port (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_acc),
    .wr_en      (dm_acc),
    .wr_data    (in_data),
    .idx        (dm_idx),
    .cen_load   (dm_cen_load),
    .wen_load   (dm_wen_load),
    .oen_load   (dm_oen_load),
    .addr_load  (dm_addr_load),
    .datain_load(dm_datain_load)
  );

endmodule

// File: tb/tb_mem_load_controller.sv
// Directed bench for mem_load_controller: vector table for a normal load plus corner-case sequences.
module tb_mem_load_controller;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [11:0]   im_words;
  logic [11:0]   dm_words;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          loading;
  logic          im_cen_load, im_wen_load, im_oen_load;
  logic [AW-1:0] im_addr_load;
  logic [DW-1:0] im_datain_load;
  logic          dm_cen_load, dm_wen_load, dm_oen_load;
  logic [AW-1:0] dm_addr_load;
  logic [DW-1:0] dm_datain_load;
  logic          cpu_rst_n;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  mem_load_controller #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .im_words      (im_words),
    .dm_words      (dm_words),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .loading       (loading),
    .im_cen_load   (im_cen_load),
    .im_wen_load   (im_wen_load),
    .im_oen_load   (im_oen_load),
    .im_addr_load  (im_addr_load),
    .im_datain_load(im_datain_load),
    .dm_cen_load   (dm_cen_load),
    .dm_wen_load   (dm_wen_load),
    .dm_oen_load   (dm_oen_load),
    .dm_addr_load  (dm_addr_load),
    .dm_datain_load(dm_datain_load),
    .cpu_rst_n     (cpu_rst_n),
    .busy          (busy),
    .done          (done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic          rdy, ld, crn, dn, bsy;
    logic          icen, iwen, ioen;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic          dcen, dwen, doen;
    logic [AW-1:0] daddr;
    logic [DW-1:0] ddata;
  } obs_t;

  typedef struct {
    logic          start;
    logic          vld;
    logic [DW-1:0] data;
    obs_t          exp;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  function automatic obs_t get_obs();
    obs_t o;
    o.rdy = in_ready;    o.ld = loading;        o.crn = cpu_rst_n;
    o.dn = done;         o.bsy = busy;
    o.icen = im_cen_load; o.iwen = im_wen_load; o.ioen = im_oen_load;
    o.iaddr = im_addr_load; o.idata = im_datain_load;
    o.dcen = dm_cen_load; o.dwen = dm_wen_load; o.doen = dm_oen_load;
    o.daddr = dm_addr_load; o.ddata = dm_datain_load;
    return o;
  endfunction

  function automatic obs_t mk(input logic rdy, ld, crn, dn, bsy, icen,
                              input logic [AW-1:0] iaddr, input logic [DW-1:0] idata,
                              input logic dcen,
                              input logic [AW-1:0] daddr, input logic [DW-1:0] ddata);
    obs_t o;
    o.rdy = rdy; o.ld = ld; o.crn = crn; o.dn = dn; o.bsy = bsy;
    o.icen = icen; o.iwen = icen; o.ioen = 1'b1; o.iaddr = iaddr; o.idata = idata;
    o.dcen = dcen; o.dwen = dcen; o.doen = 1'b1; o.daddr = daddr; o.ddata = ddata;
    return o;
  endfunction

  // Strobe monitor: logs every write and counts strobes not preceded by in_valid=1.
  wr_t  im_q[$];
  wr_t  dm_q[$];
  logic prev_vld = 1'b0;
  int   orphan   = 0;

  always @(posedge clk) prev_vld <= in_valid;

  always @(negedge clk) begin
    if (im_cen_load === 1'b0) begin
      im_q.push_back({im_addr_load, im_datain_load});
      if (!prev_vld) orphan++;
    end
    if (dm_cen_load === 1'b0) begin
      dm_q.push_back({dm_addr_load, dm_datain_load});
      if (!prev_vld) orphan++;
    end
  end

  vec_t vecs[11];
  obs_t rst_obs;

  initial begin
    int   n;
    int   k;
    int   errs;
    logic rdy_seen;

    rst_obs = mk(0, 1, 0, 0, 0, 1, 11'd0, 32'h0, 1, 11'd0, 32'h0);

    // start, in_valid, in_data | rdy ld crn done busy, IM cen/addr/data, DM cen/addr/data
    vecs[0]  = '{1'b1, 1'b0, 32'h00, mk(0,1,0,0,0, 1,11'd0,32'h00, 1,11'd0,32'h00)};
    vecs[1]  = '{1'b0, 1'b1, 32'hA0, mk(1,1,0,0,1, 1,11'd0,32'h00, 1,11'd0,32'h00)};
    vecs[2]  = '{1'b0, 1'b1, 32'hA1, mk(1,1,0,0,1, 0,11'd0,32'hA0, 1,11'd0,32'h00)};
    vecs[3]  = '{1'b0, 1'b1, 32'hA2, mk(1,1,0,0,1, 0,11'd1,32'hA1, 1,11'd0,32'h00)};
    vecs[4]  = '{1'b0, 1'b1, 32'hA3, mk(1,1,0,0,1, 0,11'd2,32'hA2, 1,11'd0,32'h00)};
    vecs[5]  = '{1'b0, 1'b1, 32'hA4, mk(1,1,0,0,1, 1,11'd2,32'hA2, 0,11'd0,32'hA3)};
    vecs[6]  = '{1'b0, 1'b1, 32'hFF, mk(0,1,0,0,1, 1,11'd2,32'hA2, 0,11'd1,32'hA4)};
    vecs[7]  = '{1'b0, 1'b1, 32'hFE, mk(0,0,0,0,1, 1,11'd2,32'hA2, 1,11'd1,32'hA4)};
    vecs[8]  = '{1'b0, 1'b0, 32'h00, mk(0,0,0,0,1, 1,11'd2,32'hA2, 1,11'd1,32'hA4)};
    vecs[9]  = '{1'b0, 1'b0, 32'h00, mk(0,0,1,1,0, 1,11'd2,32'hA2, 1,11'd1,32'hA4)};
    vecs[10] = '{1'b0, 1'b0, 32'h00, mk(0,0,1,0,0, 1,11'd2,32'hA2, 1,11'd1,32'hA4)};

    // Reset held for two edges with in_valid asserted.
    rst = 1'b1; start = 1'b0; im_words = '0; dm_words = '0;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", get_obs(), rst_obs);
    rst = 1'b0; in_valid = 1'b0;

    // Normal load: 3 IM + 2 DM words, back to back.
    im_words = 12'd3; dm_words = 12'd2;
    for (int i = 0; i < 11; i++) begin
      start = vecs[i].start; in_valid = vecs[i].vld; in_data = vecs[i].data;
      #1;
      chk($sformatf("normal_vec%0d", i), get_obs(), vecs[i].exp);
      @(negedge clk);
    end
    chk("normal_im_count", 128'(im_q.size()), 128'd3);
    chk("normal_dm_count", 128'(dm_q.size()), 128'd2);
    im_q.delete(); dm_q.delete();

    // Restart from RUN; start during LOAD_DM must be ignored; addresses restart at 0.
    start = 1'b1; im_words = 12'd1; dm_words = 12'd2; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1 chk("restart_c1", {loading, cpu_rst_n, in_ready}, 3'b101);
    in_valid = 1'b1; in_data = 32'hB0;
    @(negedge clk);
    in_data = 32'hB1; start = 1'b1; im_words = 12'd5; dm_words = 12'd5;
    #1 chk("restart_in_dm", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("ignore_start", {in_ready, busy, im_cen_load}, 3'b111);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'hB2;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("restart_drain", {in_ready, loading, busy}, 3'b011);
    n = 0;
    while (!done && n < 10) begin @(negedge clk); n++; end
    chk("restart_done", done, 1'b1);
    chk("restart_im_count", 128'(im_q.size()), 128'd1);
    chk("restart_dm_count", 128'(dm_q.size()), 128'd2);
    if (im_q.size() == 1) chk("restart_im0", im_q[0], {11'd0, 32'hB0});
    if (dm_q.size() == 2) begin
      chk("restart_dm0", dm_q[0], {11'd0, 32'hB1});
      chk("restart_dm1", dm_q[1], {11'd1, 32'hB2});
    end
    im_q.delete(); dm_q.delete();

    // Zero counts: straight to DRAIN, RUN four cycles after start.
    start = 1'b1; im_words = 12'd0; dm_words = 12'd0; in_valid = 1'b1; in_data = 32'h77;
    @(negedge clk);
    start = 1'b0;
    #1 chk("zero_c1", {loading, cpu_rst_n, in_ready, busy}, 4'b1001);
    n = 1; rdy_seen = 1'b0;
    while (!done && n < 20) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("zero_run_latency", 128'(n), 128'd4);
    chk("zero_in_ready", rdy_seen, 1'b0);
    chk("zero_cpu_rst_n", cpu_rst_n, 1'b1);
    chk("zero_strobes", 128'(im_q.size() + dm_q.size()), 128'd0);
    in_valid = 1'b0;

    // Saturation with in_valid toggling every cycle.
    orphan = 0;
    start = 1'b1; im_words = 12'hFFF; dm_words = 12'd0;
    @(negedge clk);
    start = 1'b0;
    n = 0; k = 0;
    while (!done && n < 6000) begin
      in_valid = (n % 2 == 0);
      in_data  = 32'h5000_0000 + 32'(k);
      if (in_valid) k++;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk("sat_done", done, 1'b1);
    chk("sat_im_count", 128'(im_q.size()), 128'd2048);
    chk("sat_dm_count", 128'(dm_q.size()), 128'd0);
    errs = 0;
    for (int i = 0; i < im_q.size(); i++) begin
      if (im_q[i] !== {AW'(i), 32'h5000_0000 + 32'(i)}) errs++;
    end
    chk("sat_sequence_errs", 128'(errs), 128'd0);
    chk("sat_orphan_strobes", 128'(orphan), 128'd0);
    im_q.delete(); dm_q.delete();

    // Reset one cycle after an accept: no strobes afterwards, reset values.
    start = 1'b1; im_words = 12'd5; dm_words = 12'd0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'hC0;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_state", get_obs(), rst_obs);
    in_valid = 1'b1; in_data = 32'hC1; rdy_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (in_ready) rdy_seen = 1'b1;
    end
    in_valid = 1'b0;
    chk("midrst_no_ready", rdy_seen, 1'b0);
    chk("midrst_strobes", 128'(im_q.size()), 128'd1);
    if (im_q.size() == 1) chk("midrst_pre_strobe", im_q[0], {11'd0, 32'hC0});

    // Reset in the same cycle as an accept drops the pending strobe.
    @(negedge clk);
    start = 1'b1; im_words = 12'd5;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'hD0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1 chk("pending_dropped", get_obs(), rst_obs);
    @(negedge clk);
    chk("pending_strobes", 128'(im_q.size() + dm_q.size()), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_load_controller.md
MEM_LOAD_CONTROLLER -- requirements
Module: mem_load_controller

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 11, SHALL set the memory word-address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the memory data width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 start  input  1  SHALL be a one-cycle request to begin a load session.
REQ-006 im_words  input  12  SHALL give the instruction-memory word count, sampled on an accepted start.
REQ-007 dm_words  input  12  SHALL give the data-memory word count, sampled on an accepted start.
REQ-008 in_valid  input  1  SHALL mark in_data as valid.
REQ-009 in_data  input  DATA_WIDTH  SHALL carry the load word stream: IM words first, then DM words.
REQ-010 in_ready  output  1  SHALL mark that the block accepts in_data this cycle.
REQ-011 loading  output  1  SHALL give memory ports to the loader when high.
REQ-012 im_cen_load, im_wen_load, im_oen_load  output  1 each  SHALL be the active-low IM port strobes.
REQ-013 im_addr_load  output  ADDRESS_WIDTH  SHALL be the IM write address.
REQ-014 im_datain_load  output  DATA_WIDTH  SHALL be the IM write data.
REQ-015 dm_cen_load, dm_wen_load, dm_oen_load, dm_addr_load, dm_datain_load  output  as IM  SHALL be the same signals for DM.
REQ-016 cpu_rst_n  output  1  SHALL drive the processor's active-low reset.
REQ-017 busy  output  1  SHALL be high in every state except IDLE and RUN.
REQ-018 done  output  1  SHALL pulse high for one cycle on entry to RUN.

Function
REQ-019 States SHALL be IDLE, LOAD_IM, LOAD_DM, DRAIN, RELEASE, RUN.
REQ-020 An accepted start SHALL be start=1 in IDLE or RUN.
  - start is ignored in every other state.
REQ-021 On an accepted start, the block SHALL latch each count, saturated to 2048 (values 2049..4095 become 2048).
  - It also clears both address counters.
REQ-022 From an accepted start, next state SHALL be LOAD_IM if im_words>0; else LOAD_DM if dm_words>0; else DRAIN.
REQ-023 in_ready SHALL equal 1 exactly in LOAD_IM and LOAD_DM.
  - A word is accepted only when in_valid=1 and in_ready=1.
REQ-024 A word accepted in cycle N SHALL produce a one-cycle write strobe in cycle N+1 on the selected port.
  - Strobe: cen_load=0, wen_load=0, addr_load=current index, datain_load=word.
  - The index then increments.
REQ-025 Outside a write strobe, every cen_load, wen_load and oen_load SHALL be 1.
  - Address and data outputs hold their last value.
REQ-026 Acceptance of the last IM word SHALL move the state to LOAD_DM (DM count>0) or to DRAIN.
  - Acceptance of the last DM word moves the state to DRAIN.
REQ-027 Back-to-back accepts SHALL be sustained at one word per cycle.
  - The last IM word and the first DM word may be accepted in consecutive cycles.
REQ-028 DRAIN SHALL last one cycle, so the final strobe completes while loading=1.
  - DRAIN then moves to RELEASE.
REQ-029 loading SHALL be 1 in IDLE, LOAD_IM, LOAD_DM and DRAIN, and 0 in RELEASE and RUN.
REQ-030 cpu_rst_n SHALL be 0 in every state except RUN.
REQ-031 RELEASE SHALL last exactly 2 cycles (loading=0, cpu_rst_n=0), then enter RUN.
REQ-032 An accepted start in RUN SHALL re-enter the load sequence.
  - On the next cycle: loading=1, cpu_rst_n=0.
REQ-033 in_valid without in_ready SHALL be ignored.
  - in_data is never captured outside load states.
REQ-034 All outputs except in_ready and busy SHALL be registered.

Reset
REQ-035 While rst=1, the state SHALL go to IDLE at the next edge.
  - Outputs: loading=1, cpu_rst_n=0, in_ready=0, busy=0, done=0.
  - All cen/wen/oen_load=1; addresses, data and counters=0.
REQ-036 Reset mid-session SHALL abandon the session, with no further strobes, including any pending one.

Structure
REQ-037 Package mem_load_pkg SHALL hold ADDRESS_WIDTH, DATA_WIDTH, MEM_DEPTH=2048 and the state enumeration.
REQ-038 One sub-module, load_port_driver, SHALL be instantiated twice (IM and DM).
  - It holds the address counter, write-strobe register and outputs for one RAM port.

Verification
REQ-039 Reset: rst=1 for 2 cycles -> loading=1, cpu_rst_n=0, all strobes 1, in_ready=0.
REQ-040 Normal load: im_words=3, dm_words=2, in_valid held high with data 0xA0..0xA4.
  - IM strobes at addr 0,1,2 with 0xA0..0xA2; DM strobes at addr 0,1 with 0xA3..0xA4.
  - Then DRAIN, 2 RELEASE cycles, then cpu_rst_n=1 and a one-cycle done pulse.
REQ-041 Zero counts: im_words=0, dm_words=0 -> no strobes, in_ready never 1, RUN reached 4 cycles after start.
REQ-042 Saturation and backpressure: im_words=4095, dm_words=0, with in_valid toggled every cycle.
  - Exactly 2048 IM strobes, addr 0..2047, no wrap.
  - A strobe occurs only after a cycle with in_valid=1.
REQ-043 Restart and ignore: start during LOAD_DM is ignored.
  - start in RUN -> loading=1, cpu_rst_n=0 next cycle, addresses restart at 0.
REQ-044 Mid-session reset: rst=1 during LOAD_IM, one cycle after an accept.
  - No strobe follows; the block is in IDLE with reset values.
